// File: rtl/hazard_ctl.sv
// hazard_ctl - pipeline hazard controller for the 5-stage core (IF/ID/EX/ME/WB).
//
// Compares the ID-stage source operands against the EX and ME producers and
// produces:
//   - registered EX-stage forwarding selects (valid during EX)
//   - load-use stalls, stretched by a down-counter for multi-cycle loads
//   - a mul/div busy interlock for instructions touching HI/LO or the unit
//   - branch/jump flushes, with a branch redirect overriding any stall
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset (0 = reset)
//   Src_ID / SrcVal_ID         packed ID source indices and per-operand read flags
//   UsesMulDiv_ID              ID instruction needs the mul/div unit or HI/LO
//   WriteReg_EX/RegWrite_EX    EX producer; MemToReg_EX marks it as a load
//   WriteReg_ME/RegWrite_ME    ME producer
//   MulDivStart_EX             mul/div issued this cycle
//   BranchTaken_EXM1, Jump_IDM1  redirect requests
//   Fwd_EX                     per-operand select: 0 regfile, 1 ME result, 2 WB result
//   Stall_IF, Stall_ID, Bubble_EX, Flush_ID, Flush_EX, AnyStall
//   StallCnt, FlushCnt         performance counters
//
// Optional feature macro: HAZARD_PERF_EN
//   Defined   -> StallCnt/FlushCnt count stall and flush cycles, saturating.
//   Undefined -> both counters are tied to zero.
//
// Counter state:
//   ld_cnt_q | remaining load-use bubbles after the detect cycle
//   md_cnt_q | remaining busy cycles of the mul/div unit

module hazard_ctl #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*REG_AW-1:0] Src_ID,
    input  logic [NUM_SRC-1:0]        SrcVal_ID,
    input  logic                      UsesMulDiv_ID,
    input  logic [REG_AW-1:0]         WriteReg_EX,
    input  logic                      RegWrite_EX,
    input  logic                      MemToReg_EX,
    input  logic [REG_AW-1:0]         WriteReg_ME,
    input  logic                      RegWrite_ME,
    input  logic                      MulDivStart_EX,
    input  logic                      BranchTaken_EXM1,
    input  logic                      Jump_IDM1,
    output logic [2*NUM_SRC-1:0]      Fwd_EX,
    output logic                      Stall_IF,
    output logic                      Stall_ID,
    output logic                      Bubble_EX,
    output logic                      Flush_ID,
    output logic                      Flush_EX,
    output logic                      AnyStall,
    output logic [31:0]               StallCnt,
    output logic [31:0]               FlushCnt
);

    localparam int LD_W = 3;
    localparam int MD_W = 4;

    logic [LD_W-1:0]        ld_cnt_q, ld_cnt_d;
    logic [MD_W-1:0]        md_cnt_q, md_cnt_d;
    logic [2*NUM_SRC-1:0]   fwd_q, fwd_d;

    logic [NUM_SRC-1:0]     match_ex;
    logic [NUM_SRC-1:0]     match_me;
    logic [2*NUM_SRC-1:0]   fwd_sel;

    logic                   ld_hit;
    logic                   stall_raw;
    logic                   stall;
    logic                   flush_id;
    logic                   flush_ex;

    // Per-operand producer match; register 0 is never a hazard.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [REG_AW-1:0] src;
        assign src         = Src_ID[k*REG_AW +: REG_AW];
        assign match_ex[k] = SrcVal_ID[k] & (src != '0) & RegWrite_EX & (src == WriteReg_EX);
        assign match_me[k] = SrcVal_ID[k] & (src != '0) & RegWrite_ME & (src == WriteReg_ME);
        // The EX producer is the younger one, so it takes priority.
        assign fwd_sel[2*k +: 2] = match_ex[k] ? 2'd1 :
                                   match_me[k] ? 2'd2 : 2'd0;
    end

    assign ld_hit    = MemToReg_EX & (|match_ex);
    assign stall_raw = ld_hit | (ld_cnt_q != '0) | ((md_cnt_q != '0) & UsesMulDiv_ID);

    // A taken branch kills the stalled instruction anyway, so it overrides the
    // stall. A jump loses to a stall: its flush would drop the held instruction,
    // and fetch re-issues the redirect once ID presents the jump again.
    assign stall    = reset & stall_raw & ~BranchTaken_EXM1;
    assign flush_id = reset & (BranchTaken_EXM1 | (Jump_IDM1 & ~stall_raw));
    assign flush_ex = reset & BranchTaken_EXM1;

    assign Stall_IF  = stall;
    assign Stall_ID  = stall;
    assign Bubble_EX = stall;
    assign AnyStall  = stall;
    assign Flush_ID  = flush_id;
    assign Flush_EX  = flush_ex;
    assign Fwd_EX    = fwd_q;

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        if (BranchTaken_EXM1) begin
            ld_cnt_d = '0;
        end else if (ld_hit) begin
            ld_cnt_d = LD_W'(LOAD_LAT - 1);
        end else if (ld_cnt_q != '0) begin
            ld_cnt_d = ld_cnt_q - 1'b1;
        end
    end

    // The mul/div unit is already running, so a branch does not cancel it.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (MulDivStart_EX) begin
            md_cnt_d = MD_W'(MULDIV_LAT - 1);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    // A bubble or a flushed EX slot must not carry a stale forwarding select.
    always_comb begin
        fwd_d = fwd_sel;
        if (BranchTaken_EXM1 | stall_raw) begin
            fwd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_cnt_q <= '0;
            md_cnt_q <= '0;
            fwd_q    <= '0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            md_cnt_q <= md_cnt_d;
            fwd_q    <= fwd_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((flush_id | flush_ex) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = 32'd0;
    assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl - self-checking bench for hazard_ctl.
//
// Directed scenarios for forwarding, load-use, mul/div interlock, redirects
// and reset, followed by randomized stimulus. A cycle-level reference model
// tracks the last busy cycle of the load and mul/div interlocks as absolute
// cycle numbers and recomputes every output from the hazard rules each cycle.
// Honours HAZARD_PERF_EN for the performance counter expectations.

module tb_hazard_ctl;

    localparam int REG_AW = 5;
    localparam int NS     = 2;
    localparam int LL     = 3;
    localparam int ML     = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NS*REG_AW-1:0] Src_ID;
    logic [NS-1:0]        SrcVal_ID;
    logic                 UsesMulDiv_ID;
    logic [REG_AW-1:0]    WriteReg_EX;
    logic                 RegWrite_EX;
    logic                 MemToReg_EX;
    logic [REG_AW-1:0]    WriteReg_ME;
    logic                 RegWrite_ME;
    logic                 MulDivStart_EX;
    logic                 BranchTaken_EXM1;
    logic                 Jump_IDM1;
    logic [2*NS-1:0]      Fwd_EX;
    logic                 Stall_IF, Stall_ID, Bubble_EX, Flush_ID, Flush_EX, AnyStall;
    logic [31:0]          StallCnt, FlushCnt;

    always #5 clk = ~clk;

    hazard_ctl #(
        .REG_AW     (REG_AW),
        .NUM_SRC    (NS),
        .LOAD_LAT   (LL),
        .MULDIV_LAT (ML)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Src_ID           (Src_ID),
        .SrcVal_ID        (SrcVal_ID),
        .UsesMulDiv_ID    (UsesMulDiv_ID),
        .WriteReg_EX      (WriteReg_EX),
        .RegWrite_EX      (RegWrite_EX),
        .MemToReg_EX      (MemToReg_EX),
        .WriteReg_ME      (WriteReg_ME),
        .RegWrite_ME      (RegWrite_ME),
        .MulDivStart_EX   (MulDivStart_EX),
        .BranchTaken_EXM1 (BranchTaken_EXM1),
        .Jump_IDM1        (Jump_IDM1),
        .Fwd_EX           (Fwd_EX),
        .Stall_IF         (Stall_IF),
        .Stall_ID         (Stall_ID),
        .Bubble_EX        (Bubble_EX),
        .Flush_ID         (Flush_ID),
        .Flush_EX         (Flush_EX),
        .AnyStall         (AnyStall),
        .StallCnt         (StallCnt),
        .FlushCnt         (FlushCnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int              cyc     = 0;
    int              ld_last = -1;  // last cycle the load interlock holds on its own
    int              md_last = -1;  // last cycle the mul/div unit is busy
    logic [2*NS-1:0] fwd_m   = '0;
    longint          st_m    = 0;
    longint          fl_m    = 0;

    // Observations from the most recent cycle, for directed checks
    int   stall_seen = 0;
    logic obs_stall, obs_fid, obs_fex;

    function automatic logic hit(input int k, input logic [REG_AW-1:0] wr, input logic we);
        logic [REG_AW-1:0] s;
        s = Src_ID[k*REG_AW +: REG_AW];
        return SrcVal_ID[k] && (s != 0) && we && (s == wr);
    endfunction

    task automatic run_cycle();
        logic            ldh, rs, e_stall, e_fid, e_fex;
        logic [2*NS-1:0] nf;
        #1;
        ldh = 1'b0;
        nf  = '0;
        for (int k = 0; k < NS; k++) begin
            if (MemToReg_EX && hit(k, WriteReg_EX, RegWrite_EX)) ldh = 1'b1;
            if (hit(k, WriteReg_EX, RegWrite_EX))      nf[2*k +: 2] = 2'd1;
            else if (hit(k, WriteReg_ME, RegWrite_ME)) nf[2*k +: 2] = 2'd2;
        end
        rs = ldh || (cyc <= ld_last) || ((cyc <= md_last) && UsesMulDiv_ID);
        if (!reset) begin
            e_stall = 1'b0; e_fid = 1'b0; e_fex = 1'b0;
        end else begin
            e_stall = rs && !BranchTaken_EXM1;
            e_fid   = BranchTaken_EXM1 || (Jump_IDM1 && !rs);
            e_fex   = BranchTaken_EXM1;
        end

        check("fwd_ex",    64'(Fwd_EX),    64'(fwd_m));
        check("stall_if",  64'(Stall_IF),  64'(e_stall));
        check("stall_id",  64'(Stall_ID),  64'(e_stall));
        check("bubble_ex", 64'(Bubble_EX), 64'(e_stall));
        check("any_stall", 64'(AnyStall),  64'(e_stall));
        check("flush_id",  64'(Flush_ID),  64'(e_fid));
        check("flush_ex",  64'(Flush_EX),  64'(e_fex));
        check("stall_cnt", 64'(StallCnt),  64'(st_m));
        check("flush_cnt", 64'(FlushCnt),  64'(fl_m));

        stall_seen += int'(AnyStall);
        obs_stall = AnyStall;
        obs_fid   = Flush_ID;
        obs_fex   = Flush_EX;

        if (!reset) begin
            ld_last = cyc;      // nothing busy from the next cycle on
            md_last = cyc;
            fwd_m   = '0;
            st_m    = 0;
            fl_m    = 0;
        end else begin
            if (BranchTaken_EXM1) ld_last = cyc;
            else if (ldh)         ld_last = cyc + LL - 1;
            if (MulDivStart_EX)   md_last = cyc + ML - 1;
            fwd_m = (BranchTaken_EXM1 || rs) ? '0 : nf;
`ifdef HAZARD_PERF_EN
            if (e_stall && st_m < 64'hFFFF_FFFF) st_m++;
            if ((e_fid || e_fex) && fl_m < 64'hFFFF_FFFF) fl_m++;
`endif
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 1'b1; Src_ID = '0; SrcVal_ID = '0; UsesMulDiv_ID = 1'b0;
        WriteReg_EX = '0; RegWrite_EX = 1'b0; MemToReg_EX = 1'b0;
        WriteReg_ME = '0; RegWrite_ME = 1'b0; MulDivStart_EX = 1'b0;
        BranchTaken_EXM1 = 1'b0; Jump_IDM1 = 1'b0;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(negedge clk);
        run_cycle();
        run_cycle();
        drain(2);

        // EX producer forwarding, no stall
        stall_seen = 0;
        RegWrite_EX = 1'b1; WriteReg_EX = 5'd3; Src_ID = {5'd0, 5'd3}; SrcVal_ID = 2'b01;
        run_cycle();
        check("add_fwd_rs", 64'(Fwd_EX[1:0]), 64'd1);
        check("add_no_stall", 64'(stall_seen), 64'd0);

        // EX priority over ME, ME alone, register 0
        idle();
        RegWrite_ME = 1'b1; WriteReg_ME = 5'd5; RegWrite_EX = 1'b1; WriteReg_EX = 5'd5;
        Src_ID = {5'd5, 5'd0}; SrcVal_ID = 2'b10;
        run_cycle();
        check("fwd_ex_prio", 64'(Fwd_EX[3:2]), 64'd1);
        RegWrite_EX = 1'b0;
        run_cycle();
        check("fwd_me", 64'(Fwd_EX[3:2]), 64'd2);
        RegWrite_EX = 1'b1; WriteReg_EX = '0; WriteReg_ME = '0; Src_ID = '0; SrcVal_ID = 2'b11;
        run_cycle();
        check("fwd_r0", 64'(Fwd_EX), 64'd0);

        // Load-use: LOAD_LAT bubbles, then forward from the load result
        drain(2);
        stall_seen = 0;
        RegWrite_EX = 1'b1; MemToReg_EX = 1'b1; WriteReg_EX = 5'd7;
        Src_ID = {5'd0, 5'd7}; SrcVal_ID = 2'b01;
        run_cycle();
        RegWrite_EX = 1'b0; MemToReg_EX = 1'b0; RegWrite_ME = 1'b1; WriteReg_ME = 5'd7;
        for (int i = 0; i < 4; i++) run_cycle();
        check("ld_stall_cycles", 64'(stall_seen), 64'(LL));
        check("ld_fwd_after", 64'(Fwd_EX[1:0]), 64'd2);

        // Mul/div interlock, single start
        drain(2);
        stall_seen = 0;
        MulDivStart_EX = 1'b1; UsesMulDiv_ID = 1'b1;
        run_cycle();
        MulDivStart_EX = 1'b0;
        for (int i = 0; i < 5; i++) run_cycle();
        check("md_stall_cycles", 64'(stall_seen), 64'(ML - 1));

        // Mul/div restart two cycles after the first start
        drain(2);
        stall_seen = 0;
        UsesMulDiv_ID = 1'b1;
        MulDivStart_EX = 1'b1; run_cycle();
        MulDivStart_EX = 1'b0; run_cycle();
        MulDivStart_EX = 1'b1; run_cycle();
        MulDivStart_EX = 1'b0;
        for (int i = 0; i < 5; i++) run_cycle();
        check("md_restart_cycles", 64'(stall_seen), 64'(2 + ML - 1));

        // Load-use together with a taken branch
        drain(4);
        RegWrite_EX = 1'b1; MemToReg_EX = 1'b1; WriteReg_EX = 5'd7;
        Src_ID = {5'd0, 5'd7}; SrcVal_ID = 2'b01; BranchTaken_EXM1 = 1'b1;
        run_cycle();
        check("br_flush_id", 64'(obs_fid), 64'd1);
        check("br_flush_ex", 64'(obs_fex), 64'd1);
        check("br_no_stall", 64'(obs_stall), 64'd0);
        idle();
        run_cycle();
        check("br_no_stall_next", 64'(obs_stall), 64'd0);

        // Jump alone
        Jump_IDM1 = 1'b1;
        run_cycle();
        check("jmp_flush_id", 64'(obs_fid), 64'd1);
        check("jmp_flush_ex", 64'(obs_fex), 64'd0);

        // Reset in the middle of a load stall
        idle();
        RegWrite_EX = 1'b1; MemToReg_EX = 1'b1; WriteReg_EX = 5'd7;
        Src_ID = {5'd0, 5'd7}; SrcVal_ID = 2'b01;
        run_cycle();
        RegWrite_EX = 1'b0; MemToReg_EX = 1'b0;
        run_cycle();
        reset = 1'b0;
        run_cycle();
        check("rst_stall_off", 64'(obs_stall), 64'd0);
        idle();
        stall_seen = 0;
        for (int i = 0; i < 3; i++) run_cycle();
        check("rst_no_residual", 64'(stall_seen), 64'd0);

        // Four stall cycles, then reset clears the counter
        drain(1);
        UsesMulDiv_ID = 1'b1; MulDivStart_EX = 1'b1;
        for (int i = 0; i < 5; i++) run_cycle();
`ifdef HAZARD_PERF_EN
        check("perf_stall_4", 64'(StallCnt), 64'd4);
`else
        check("perf_stall_tied", 64'(StallCnt), 64'd0);
`endif
        idle();
        reset = 1'b0;
        run_cycle();
        check("perf_stall_rst", 64'(StallCnt), 64'd0);

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            reset            = ($urandom_range(0, 99) > 2);
            Src_ID           = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            SrcVal_ID        = 2'($urandom_range(0, 3));
            UsesMulDiv_ID    = ($urandom_range(0, 99) < 30);
            WriteReg_EX      = 5'($urandom_range(0, 3));
            RegWrite_EX      = ($urandom_range(0, 99) < 60);
            MemToReg_EX      = ($urandom_range(0, 99) < 30);
            WriteReg_ME      = 5'($urandom_range(0, 3));
            RegWrite_ME      = ($urandom_range(0, 99) < 60);
            MulDivStart_EX   = ($urandom_range(0, 99) < 10);
            BranchTaken_EXM1 = ($urandom_range(0, 99) < 10);
            Jump_IDM1        = ($urandom_range(0, 99) < 10);
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
